mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous unified memory (von Neumann image) between the instruction-fetch port and the MEM-stage data port of the 5-stage pipeline.
- Issues at most one memory access per cycle.
- Returns read data one cycle after grant and drives per-stage stall lines back to the pipeline.
- The data port has fixed priority; a starvation counter guarantees forward progress for fetch.

Parameters:
- ADDR_W, 14: word-address width of the memory (2^14 words = 64 KiB, matching the 16-bit byte window).
- DATA_W, 32: data width.
- STARVE_LIMIT, 3: consecutive denied fetch cycles (1..15) after which fetch wins one arbitration.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high with stable if_addr until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  if_rdata valid (registered, one cycle after if_gnt).
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held with stable d_we/d_addr/d_wdata until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data access accepted this cycle (combinational).
- d_rvalid  out  1  d_rdata valid (loads only, one cycle after d_gnt).
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word address = granted_addr[ADDR_W+1:2].
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0.
- stall_if  out  1  if_req & ~if_gnt.
- stall_mem  out  1  d_req & ~d_gnt.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registered outputs are 0: if_rvalid, d_rvalid, if_rdata, d_rdata.
  - starve_cnt = 0; FSM goes to IDLE.
  - Any in-flight read is discarded; no rvalid appears after reset deasserts.
  - Combinational outputs follow their inputs but are forced to 0 while reset=0.
- Grant rule, evaluated per cycle:
  - d_req only: data is granted.
  - if_req only: fetch is granted.
  - Both requesting: fetch is granted iff starve_cnt == STARVE_LIMIT; otherwise data is granted.
  - Neither: no grant, mem_en = 0.
  - if_gnt and d_gnt are never both 1.
- Memory drive:
  - mem_en = if_gnt | d_gnt.
  - mem_we = d_gnt & d_we.
  - mem_addr and mem_wdata are muxed from the granted port. Low two address bits are ignored; upper bits above ADDR_W+1 are ignored (wrap within 64 KiB).
- starve_cnt (4 bits):
  - Increments when if_req & ~if_gnt.
  - Clears when if_gnt or ~if_req.
  - Saturates at STARVE_LIMIT.
- FSM records the owner of the outstanding read:
  - States: IDLE, RD_IF, RD_D.
  - Next state: RD_IF if if_gnt; RD_D if d_gnt & ~d_we; else IDLE.
  - It transitions every cycle, so back-to-back reads are supported at full throughput.
- Read return:
  - In RD_IF: if_rvalid = 1 and if_rdata <= mem_rdata.
  - In RD_D: d_rvalid = 1 and d_rdata <= mem_rdata.
  - rdata registers hold their value when rvalid = 0.
- Stores: complete on the d_gnt cycle; no rvalid is produced.
- Latency: grant in cycle N, data in cycle N+1. An uncontended stream yields one access per cycle.
- Request dropped before grant: allowed; no access is issued and starve_cnt clears.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined:
  - Adds output conflict_cnt[31:0]: increments on every cycle with if_req & d_req.
  - Adds output starve_win_cnt[15:0]: increments when fetch is granted through the starve rule.
  - Both reset to 0 and wrap on overflow.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, RD_IF, RD_D}.
  - Constants ARB_DEFAULT_STARVE = 3 and ARB_CNT_W = 4.
- Sub-module mem_arb_starve_ctr: the saturating starvation counter. Output limit_hit = (cnt == STARVE_LIMIT).
- Grant logic, FSM and return registers stay in mem_arbiter.

Test Plan:
1. Fetch only:
   - Stimulus: if_req = 1 with if_addr = 0x0, 0x4, 0x8; memory preloaded with 0x11, 0x22, 0x33.
   - Response: if_gnt every cycle; if_rvalid from the next cycle with if_rdata 0x11, 0x22, 0x33; stall_if = 0.
2. Store then load:
   - Stimulus: d_req, d_we = 1, d_addr = 0x40, d_wdata = 0xDEADBEEF; then a load from 0x40.
   - Response: mem_we = 1, mem_addr = 0x10; d_rvalid one cycle after the load grant with d_rdata = 0xDEADBEEF.
3. Contention with STARVE_LIMIT = 3:
   - Stimulus: if_req and d_req held high continuously.
   - Response: d_gnt for 3 cycles, then if_gnt for 1 cycle, repeating; stall_if high on the 3 denied cycles.
4. Address wrap:
   - Stimulus: d_addr = 0x0001_0004 (load).
   - Response: mem_addr = 0x0001, same as 0x4.
5. Reset mid-read:
   - Stimulus: if_gnt at cycle N; reset = 0 asserted asynchronously before cycle N+1 edge.
   - Response: if_rvalid stays 0; after release, FSM is IDLE and starve_cnt = 0.
6. With MEM_ARB_PERF_EN:
   - Stimulus: 8 cycles of dual requests.
   - Response: conflict_cnt = 8; starve_win_cnt = 2.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

    // Owner of the read whose data returns in the current cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_D  = 2'd2
    } arb_state_e;

    localparam int ARB_DEFAULT_STARVE = 3;
    localparam int ARB_CNT_W          = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive cycles in which a pending fetch was
// denied; limit_hit tells the arbiter that fetch must win next.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_DEFAULT_STARVE
) (
    input  logic clock,
    input  logic reset,
    input  logic if_req,
    input  logic if_gnt,
    output logic limit_hit
);

    localparam logic [ARB_CNT_W-1:0] LIMIT = ARB_CNT_W'(STARVE_LIMIT);

    logic [ARB_CNT_W-1:0] cnt_reg;
    logic [ARB_CNT_W-1:0] cnt_next;

    // Count denied fetch cycles; any fetch grant or dropped request restarts.
    always_comb begin
        cnt_next = cnt_reg;
        if (if_gnt || !if_req) begin
            cnt_next = '0;
        end else if (cnt_reg != LIMIT) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign limit_hit = (cnt_reg == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between instruction
// fetch and the MEM-stage data port. Data has fixed priority; fetch wins
// after STARVE_LIMIT consecutive denials. Read data returns one cycle after
// grant. Optional performance counters: define MEM_ARB_PERF_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = ARB_DEFAULT_STARVE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       conflict_cnt,
    output logic [15:0]       starve_win_cnt
`endif
);

    arb_state_e        state_reg;
    arb_state_e        state_next;
    logic              limit_hit;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;
    logic              unused_addr_bits;

    mem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_gnt    (if_gnt),
        .limit_hit (limit_hit)
    );

    // Grant selection: data first unless fetch has been starved long enough.
    // Everything is held low while reset is asserted.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (reset) begin
            if (d_req && !(if_req && limit_hit)) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    assign stall_if  = reset & if_req & ~if_gnt;
    assign stall_mem = reset & d_req & ~d_gnt;

    // Memory port is driven from whichever side was granted.
    assign sel_addr  = d_gnt ? d_addr : if_addr;
    assign mem_en    = if_gnt | d_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_addr  = mem_en ? sel_addr[ADDR_W+1:2] : '0;
    assign mem_wdata = d_gnt ? d_wdata : '0;

    // Byte-offset and above-window bits are deliberately dropped (wrap).
    assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};

    // Next owner of the read data: decided fresh each cycle so reads pipeline.
    always_comb begin
        state_next = IDLE;
        if (if_gnt) begin
            state_next = RD_IF;
        end else if (d_gnt && !d_we) begin
            state_next = RD_D;
        end
    end

    // Read-owner state register; reset discards any in-flight read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture returning words so each port's data holds between reads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
        end else begin
            if (state_reg == RD_IF) begin
                if_rdata_reg <= mem_rdata;
            end
            if (state_reg == RD_D) begin
                d_rdata_reg <= mem_rdata;
            end
        end
    end

    // During the return cycle the memory word passes straight through so it
    // lines up with rvalid; otherwise the last captured word is presented.
    assign if_rvalid = (state_reg == RD_IF);
    assign d_rvalid  = (state_reg == RD_D);
    assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_reg;
    assign d_rdata   = d_rvalid ? mem_rdata : d_rdata_reg;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] conflict_reg;
    logic [15:0] starve_win_reg;
    logic        starve_win;

    // Fetch can only beat a concurrent data request via the starve rule.
    assign starve_win = if_gnt & d_req;

    // Wrapping event counters for contention and forced fetch wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conflict_reg   <= '0;
            starve_win_reg <= '0;
        end else begin
            if (if_req && d_req) begin
                conflict_reg <= conflict_reg + 32'd1;
            end
            if (starve_win) begin
                starve_win_reg <= starve_win_reg + 16'd1;
            end
        end
    end

    assign conflict_cnt   = conflict_reg;
    assign starve_win_cnt = starve_win_reg;
`endif

endmodule
